mfc_memory: RTL and testbench

- Byte-addressed, big-endian instruction/data memory that sits directly downstream of the CPU control unit.
- Consumes memEn, memRW and wordSel from the control unit, the address from MAR and write data from the datapath.
- Returns read data to the IR/MDR path and signals completion with mfc (memory function complete).
- Every access takes a fixed, programmable latency, then holds mfc until the control unit releases memEn.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/mfc_byte_array.sv | 31 +++
 rtl/mfc_memory.sv | 162 ++++++++++++++++
 tb/tb_mfc_memory.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: memory access size, direction and memory FSM states.
package cpu_pkg;

    typedef enum logic [1:0] {
        WS_BYTE = 2'b00,
        WS_HALF = 2'b01,
        WS_WORD = 2'b10,
        WS_RSVD = 2'b11
    } word_sel_e;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_WAIT = 2'b01,
        MS_DONE = 2'b10
    } mem_state_e;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mfc_byte_array.sv
// Byte storage with four byte-lane write enables and a 4-byte big-endian read port.
module mfc_byte_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-3:0] base,
    input  logic [3:0]        lane_we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [7:0] mem [2**ADDR_W];

    // NOTE: storage has no reset; contents survive clr and a reset would defeat RAM inference.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem[{base, 2'(i)}] <= wdata[31-8*i -: 8];
            end
        end
    end

    // Lane i is byte offset i from the aligned base; offset 0 is the most significant byte.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            rdata[31-8*i -: 8] = mem[{base, 2'(i)}];
        end
    end

endmodule

// File: rtl/mfc_memory.sv
// Big-endian byte-addressed memory with fixed access latency and mfc handshake.
// Optional MFC_MEMORY_ALIGN_FAULT_EN adds alignFault instead of silent alignment.
module mfc_memory
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              memEn,
    input  logic              memRW,
    input  logic [1:0]        wordSel,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       dataIn,
    output logic [31:0]       dataOut,
`ifdef MFC_MEMORY_ALIGN_FAULT_EN
    output logic              alignFault,
`endif
    output logic              mfc
);

    mem_state_e        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_rw;
    word_sel_e         lat_ws;
    logic [31:0]       lat_din;

    logic              access;
    logic              no_access;
    logic [1:0]        off;
    logic [3:0]        lane_mask;
    logic [3:0]        lane_we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [31:0]       rd_val;

    assign access = (state == MS_WAIT) && (cnt == '0);
    assign mfc    = (state == MS_DONE);

`ifdef MFC_MEMORY_ALIGN_FAULT_EN
    assign no_access = (lat_ws == WS_RSVD)
                    || (lat_ws == WS_HALF && lat_addr[0])
                    || (lat_ws == WS_WORD && lat_addr[1:0] != 2'b00);
`else
    assign no_access = (lat_ws == WS_RSVD);
`endif

    always_comb begin
        state_next = state;
        case (state)
            MS_IDLE: if (memEn)      state_next = MS_WAIT;
            MS_WAIT: if (cnt == '0)  state_next = MS_DONE;
            MS_DONE: if (!memEn)     state_next = MS_IDLE;
            default:                 state_next = MS_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= MS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (state == MS_IDLE && memEn) begin
            cnt <= CNT_W'(LATENCY - 1);
        end else if (state == MS_WAIT && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (state == MS_IDLE && memEn) begin
            lat_addr <= address;
            lat_rw   <= memRW;
            lat_ws   <= word_sel_e'(wordSel);
            lat_din  <= dataIn;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        off       = 2'b00;
        lane_mask = 4'b0000;
        wdata     = lat_din;
        case (lat_ws)
            WS_BYTE: begin
                off       = lat_addr[1:0];
                lane_mask = 4'b0001 << off;
                wdata     = {4{lat_din[7:0]}};
            end
            WS_HALF: begin
                off       = {lat_addr[1], 1'b0};
                lane_mask = 4'b0011 << off;
                wdata     = {2{lat_din[15:0]}};
            end
            WS_WORD: begin
                lane_mask = 4'b1111;
            end
            default: ;
        endcase
    end

    assign lane_we = (access && lat_rw == MEM_WRITE && !no_access) ? lane_mask : 4'b0000;

    always_comb begin
        rd_val = '0;
        case (lat_ws)
            WS_BYTE: begin
                case (off)
                    2'd0:    rd_val = {24'b0, rdata[31:24]};
                    2'd1:    rd_val = {24'b0, rdata[23:16]};
                    2'd2:    rd_val = {24'b0, rdata[15:8]};
                    default: rd_val = {24'b0, rdata[7:0]};
                endcase
            end
            WS_HALF: rd_val = off[1] ? {16'b0, rdata[15:0]} : {16'b0, rdata[31:16]};
            WS_WORD: rd_val = rdata;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dataOut <= '0;
        end else if (access && lat_rw == MEM_READ) begin
`ifdef MFC_MEMORY_ALIGN_FAULT_EN
            if (!no_access) dataOut <= rd_val;
`else
            dataOut <= rd_val;
`endif
        end
    end

`ifdef MFC_MEMORY_ALIGN_FAULT_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            alignFault <= 1'b0;
        end else if (access) begin
            alignFault <= no_access;
        end else if (state == MS_DONE && !memEn) begin
            alignFault <= 1'b0;
        end
    end
`endif

    mfc_byte_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .base    (lat_addr[ADDR_W-1:2]),
        .lane_we (lane_we),
        .wdata   (wdata),
        .rdata   (rdata)
    );

endmodule

// File: tb/tb_mfc_memory.sv
// Self-checking bench for mfc_memory: directed table, handshake/reset sequences, random vs model.
module tb_mfc_memory;
    import cpu_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic        memEn;
    logic        memRW;
    logic [1:0]  wordSel;
    logic [7:0]  address;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        mfc;
`ifdef MFC_MEMORY_ALIGN_FAULT_EN
    logic        alignFault;
`endif

    mfc_memory #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .clr        (clr),
        .memEn      (memEn),
        .memRW      (memRW),
        .wordSel    (wordSel),
        .address    (address),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
`ifdef MFC_MEMORY_ALIGN_FAULT_EN
        .alignFault (alignFault),
`endif
        .mfc        (mfc)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: flat byte array plus the last value presented on dataOut.
    logic [7:0]  model_mem [256];
    logic [31:0] model_dout;

    typedef struct {
        logic        rw;
        logic [1:0]  ws;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_access(input logic rw, input logic [1:0] ws,
                                                 input logic [7:0] addr, input logic [31:0] din);
        int n;
        int a;
        logic [31:0] v;
        case (ws)
            2'b00:   n = 1;
            2'b01:   n = 2;
            2'b10:   n = 4;
            default: n = 0;
        endcase
        if (n == 0) begin
            if (rw == MEM_READ) model_dout = 32'h0;
            return model_dout;
        end
        a = int'(addr) - (int'(addr) % n);
        if (rw == MEM_READ) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(model_mem[a+i]);
            model_dout = v;
        end else begin
            for (int i = 0; i < n; i++) model_mem[a+i] = 8'(din >> (8*(n-1-i)));
        end
        return model_dout;
    endfunction

    // Called at posedge+1; leaves memEn high with mfc seen (or budget spent).
    task automatic start_access(input logic rw, input logic [1:0] ws, input logic [7:0] addr,
                                input logic [31:0] din, output int lat);
        int edges;
        memEn   = 1'b1;
        memRW   = rw;
        wordSel = ws;
        address = addr;
        dataIn  = din;
        edges   = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                address = 8'($urandom);
                dataIn  = $urandom;
                wordSel = 2'($urandom);
                memRW   = 1'($urandom);
            end
        end while (!mfc && edges < 40);
        lat = edges - 1;
    endtask

    task automatic end_access(input string name);
        logic [31:0] held;
        held  = dataOut;
        memEn = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_mfc_drop"}, 32'(mfc), 32'h0);
        check({name, "_dout_keep"}, dataOut, held);
    endtask

    task automatic run_access(input string name, input logic rw, input logic [1:0] ws,
                              input logic [7:0] addr, input logic [31:0] din, input logic [31:0] exp);
        int lat;
        start_access(rw, ws, addr, din, lat);
        check({name, "_latency"}, 32'(lat), 32'(LATENCY));
        check({name, "_mfc"}, 32'(mfc), 32'h1);
        check({name, "_data"}, dataOut, exp);
        end_access(name);
    endtask

    initial begin
        int          lat;
        logic [31:0] e;
        logic        rw;
        logic [1:0]  ws;
        logic [7:0]  ad;
        logic [31:0] di;

        vecs[0]  = '{MEM_WRITE, WS_WORD, 8'h04, 32'hDEADBEEF, 32'h00000000};
        vecs[1]  = '{MEM_READ,  WS_WORD, 8'h04, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{MEM_READ,  WS_BYTE, 8'h05, 32'h0,        32'h000000AD};
        vecs[3]  = '{MEM_READ,  WS_HALF, 8'h06, 32'h0,        32'h0000BEEF};
        vecs[4]  = '{MEM_READ,  WS_HALF, 8'h07, 32'h0,        32'h0000BEEF};
        vecs[5]  = '{MEM_WRITE, WS_BYTE, 8'h07, 32'hFFFFFF11, 32'h0000BEEF};
        vecs[6]  = '{MEM_READ,  WS_WORD, 8'h04, 32'h0,        32'hDEADBE11};
        vecs[7]  = '{MEM_READ,  WS_BYTE, 8'h04, 32'h0,        32'h000000DE};
        vecs[8]  = '{MEM_READ,  WS_HALF, 8'h05, 32'h0,        32'h0000DEAD};
        vecs[9]  = '{MEM_READ,  WS_WORD, 8'h06, 32'h0,        32'hDEADBE11};
        vecs[10] = '{MEM_WRITE, WS_HALF, 8'h0E, 32'h1234CAFE, 32'hDEADBE11};
        vecs[11] = '{MEM_READ,  WS_WORD, 8'h0C, 32'h0,        32'h0000CAFE};
        vecs[12] = '{MEM_READ,  WS_RSVD, 8'h04, 32'h0,        32'h00000000};
        vecs[13] = '{MEM_WRITE, WS_RSVD, 8'h0C, 32'hFFFFFFFF, 32'h00000000};
        vecs[14] = '{MEM_READ,  WS_WORD, 8'h0C, 32'h0,        32'h0000CAFE};
        vecs[15] = '{MEM_WRITE, WS_WORD, 8'hFC, 32'h01020304, 32'h0000CAFE};
        vecs[16] = '{MEM_READ,  WS_BYTE, 8'hFF, 32'h0,        32'h00000004};

        clr = 1'b1; memEn = 1'b0; memRW = 1'b0; wordSel = 2'b00; address = '0; dataIn = '0;
        model_dout = 32'h0;
        @(posedge clk);
        #1;
        check("reset_mfc", 32'(mfc), 32'h0);
        check("reset_dout", dataOut, 32'h0);
        #2 clr = 1'b0;
        @(posedge clk);
        #1;
        check("idle_mfc", 32'(mfc), 32'h0);

        // Known-zero contents everywhere before directed tests.
        for (int i = 0; i < 64; i++) begin
            e = model_access(MEM_WRITE, WS_WORD, 8'(i*4), 32'h0);
            run_access("init", MEM_WRITE, WS_WORD, 8'(i*4), 32'h0, e);
        end

        for (int i = 0; i < 17; i++) begin
            e = model_access(vecs[i].rw, vecs[i].ws, vecs[i].addr, vecs[i].din);
            run_access($sformatf("vec%0d", i), vecs[i].rw, vecs[i].ws, vecs[i].addr,
                       vecs[i].din, vecs[i].exp);
        end

        // Handshake hold: memEn stays high in DONE, no second access.
        e = model_access(MEM_WRITE, WS_WORD, 8'h20, 32'hA5A5A5A5);
        start_access(MEM_WRITE, WS_WORD, 8'h20, 32'hA5A5A5A5, lat);
        check("hold_latency", 32'(lat), 32'(LATENCY));
        for (int k = 0; k < 4; k++) begin
            dataIn  = $urandom;
            address = 8'h20;
            memRW   = MEM_WRITE;
            @(posedge clk);
            #1;
            check("hold_mfc", 32'(mfc), 32'h1);
            check("hold_dout", dataOut, e);
        end
        end_access("hold");
        e = model_access(MEM_READ, WS_WORD, 8'h20, 32'h0);
        run_access("hold_readback", MEM_READ, WS_WORD, 8'h20, 32'h0, 32'hA5A5A5A5);

        // Mid-cycle clr while DONE with nonzero dataOut.
        e = model_access(MEM_READ, WS_WORD, 8'h04, 32'h0);
        start_access(MEM_READ, WS_WORD, 8'h04, 32'h0, lat);
        check("pre_clr_data", dataOut, 32'hDEADBE11);
        #2 clr = 1'b1;
        #1;
        check("clr_mfc", 32'(mfc), 32'h0);
        check("clr_dout", dataOut, 32'h0);
        memEn = 1'b0;
        #1 clr = 1'b0;
        model_dout = 32'h0;
        @(posedge clk);
        #1;
        check("post_clr_mfc", 32'(mfc), 32'h0);
        e = model_access(MEM_READ, WS_WORD, 8'h04, 32'h0);
        run_access("post_clr_read", MEM_READ, WS_WORD, 8'h04, 32'h0, 32'hDEADBE11);

        // Abort a write in WAIT.
        memEn = 1'b1; memRW = MEM_WRITE; wordSel = WS_WORD; address = 8'h08; dataIn = 32'h12345678;
        @(posedge clk);
        #1;
        check("abort_wait_mfc", 32'(mfc), 32'h0);
        #1 clr = 1'b1;
        #1;
        check("abort_mfc", 32'(mfc), 32'h0);
        clr   = 1'b0;
        memEn = 1'b0;
        model_dout = 32'h0;
        @(posedge clk);
        #1;
        e = model_access(MEM_READ, WS_WORD, 8'h08, 32'h0);
        run_access("abort_read", MEM_READ, WS_WORD, 8'h08, 32'h0, 32'h00000000);

`ifdef MFC_MEMORY_ALIGN_FAULT_EN
        e = model_dout;
        start_access(MEM_READ, WS_WORD, 8'h09, 32'h0, lat);
        check("fault_mfc", 32'(mfc), 32'h1);
        check("fault_flag", 32'(alignFault), 32'h1);
        check("fault_dout", dataOut, e);
        end_access("fault");
        check("fault_clear", 32'(alignFault), 32'h0);
`else
        // Randomized accesses against the model.
        for (int i = 0; i < 300; i++) begin
            rw = 1'($urandom_range(0, 1));
            ws = 2'($urandom_range(0, 3));
            ad = 8'($urandom_range(0, 255));
            di = $urandom;
            e  = model_access(rw, ws, ad, di);
            run_access($sformatf("rnd%0d", i), rw, ws, ad, di, e);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
